decode_stage_pipe: RTL and testbench
====================================

Name: decode_stage_pipe

Overview:
Parametrised successor to the combinational decode/operand-read stage. It registers decoded operands into a one-entry output slot with valid/ready handshakes, and forwards from NFWD in-flight pipeline sources with youngest-first priority. When a producer's data is not yet available (e.g. a load in flight), it waits inside the slot for in-order writebacks instead of stalling upstream combinationally. It sits between fetch and execute; the control decoder and immgen stay outside and feed the register indices.

Parameters:
XLEN, 32, data width
REGW, 6, register index width; MSB is the float-file flag, so index 0 is integer x0
NFWD, 2, number of forwarding sources; index 0 is the youngest (E), higher indices are older (M, ...)
GHW, 9, width of the pc_xor_global_history field

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
flush  in  1  discard the slot and the in-flight capture
in_valid  in  1  upstream instruction valid
in_ready  out  1  stage can accept this cycle
in_pc  in  32  instruction PC
in_instr  in  32  raw instruction
in_prediction  in  1  branch prediction bit
in_ghist  in  GHW  pc_xor_global_history
in_rs0, in_rs1, in_rd  in  REGW each  register indices with flag, from the control decoder
rf_raddr0, rf_raddr1  out  REGW each  register-file read addresses (combinational = in_rs0/in_rs1)
rf_rdata0, rf_rdata1  in  XLEN each  register-file read data, same cycle
fwd_valid  in  NFWD  source n holds a register-writing instruction
fwd_rd  in  NFWD*REGW  destination index per source
fwd_ready  in  NFWD  source n data is final
fwd_data  in  NFWD*XLEN  data per source
wb_valid  in  1  in-order writeback commit
wb_rd  in  REGW  writeback index
wb_data  in  XLEN  writeback data
out_valid  out  1  slot holds a fully resolved instruction
out_ready  in  1  downstream accepts
out_pc, out_instr, out_prediction, out_ghist, out_rs0, out_rs1, out_rd  out  matching widths  registered copies
out_rdata0, out_rdata1  out  XLEN each  resolved operands

Behaviour:
- Reset (rstn=0, async): occ=0, out_valid=0, pend0 and pend1 counters=0. All out_* data registers clear to 0. in_ready=1 after reset.
- in_ready = !occ || (out_valid && out_ready). There is no combinational path from fwd_* to in_ready.
- Capture happens on in_valid && in_ready && !flush. On capture, all in_* fields are registered, occ is set to 1, and each operand k (k=0,1) resolves as follows, in priority order:
  1. Index is 0: data is 0, pend=0.
  2. Otherwise, let the matches be the sources n with fwd_valid[n] && fwd_rd[n]==idx. If any matches exist, take the lowest matching n.
     - If fwd_ready[n]=1: take fwd_data[n], pend=0.
     - If fwd_ready[n]=0: pend = popcount(matches), and the data register is don't-care.
  3. Else, if wb_valid && wb_rd==idx: take wb_data (bypass of the same-cycle write).
  4. Else: take rf_rdata.
- Pending resolution: while occ and pend_k>0, each wb_valid with wb_rd==out_rs_k decrements pend_k. The transition to 0 loads wb_data into out_rdata_k. Both operands may resolve in the same cycle. Commits are in order, so the last matching commit is the youngest producer.
- out_valid = occ && pend0==0 && pend1==0, registered so it is asserted the cycle after the final resolution or capture. Latency from capture with no hazard: out_valid rises on the next edge.
- Handshake: while out_valid && !out_ready, all out_* hold stable.
- Simultaneous dequeue and capture: the slot is replaced in the same edge, so no bubble occurs.
- flush: has priority over capture and dequeue. Next edge: occ=0, pend=0, out_valid=0. in_ready is unaffected during the flush cycle, but nothing is captured.
- Width rule: the pend counters are clog2(NFWD+1) bits and must never underflow. A wb that does not match, or a wb arriving when pend=0, leaves pend unchanged.
- Reset mid-pend: returns immediately to the reset state.

Decomposition:
- Shared package: the DecodeSlot struct (pc, instr, prediction, ghist, rs0/rs1/rd, rdata0/1) and the REGW/GHW defaults.
- One sub-module, operand_resolve, instantiated twice. It is combinational: it takes an index plus the fwd/wb/rf inputs and produces the capture data and the initial pend count.

Test Plan:
- No hazard: rs0=5, rf_rdata0=0x11, no fwd match -> out_valid=1 next cycle, out_rdata0=0x11.
- Priority: fwd0 rd=5 data 0xA ready; fwd1 rd=5 data 0xB ready -> out_rdata0=0xA.
- Load pending: fwd0 and fwd1 both rd=7 with ready=0; rs1=7 -> pend1=2 and out_valid=0. Then wb rd7 0x1, then wb rd7 0x2 -> out_valid=1 one cycle after the second wb, out_rdata1=0x2.
- Backpressure: out_ready=0 for 3 cycles with a valid slot -> in_ready=0 and out_* stable; out_ready=1 together with in_valid -> back-to-back replacement with no bubble.
- Flush during pend: pend0=1, flush=1 -> out_valid=0 and in_ready=1 next cycle; a later wb rd match has no effect.
- x0 and reset: rs0=0 with fwd0 rd=0 data 0xFFFF -> out_rdata0=0. Assert rstn=0 while pending -> out_valid=0 immediately, all out_* equal 0.

Source files
------------

// File: rtl/decode_stage_pipe_pkg.sv
// Shared types and default widths for the registered decode/operand-read stage.
package decode_stage_pipe_pkg;

    localparam int XLEN_DEF = 32;
    localparam int REGW_DEF = 6;
    localparam int GHW_DEF  = 9;
    localparam int NFWD_DEF = 2;

    typedef struct packed {
        logic [31:0]          pc;
        logic [31:0]          instr;
        logic                 prediction;
        logic [GHW_DEF-1:0]   ghist;
        logic [REGW_DEF-1:0]  rs0;
        logic [REGW_DEF-1:0]  rs1;
        logic [REGW_DEF-1:0]  rd;
        logic [XLEN_DEF-1:0]  rdata0;
        logic [XLEN_DEF-1:0]  rdata1;
    } decode_slot_t;

endpackage

// File: rtl/decode_stage_pipe_operand_resolve.sv
// Combinational operand source selection: x0, youngest forwarding source, same-cycle
// writeback bypass, then register file. An unready forward yields a pending count.
module operand_resolve
    import decode_stage_pipe_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int REGW = REGW_DEF,
    parameter int NFWD = NFWD_DEF,
    parameter int PW   = $clog2(NFWD + 1)
) (
    input  logic [REGW-1:0]      idx_i,
    input  logic [NFWD-1:0]      fwd_valid_i,
    input  logic [NFWD*REGW-1:0] fwd_rd_i,
    input  logic [NFWD-1:0]      fwd_ready_i,
    input  logic [NFWD*XLEN-1:0] fwd_data_i,
    input  logic                 wb_valid_i,
    input  logic [REGW-1:0]      wb_rd_i,
    input  logic [XLEN-1:0]      wb_data_i,
    input  logic [XLEN-1:0]      rf_rdata_i,
    output logic [XLEN-1:0]      data_o,
    output logic [PW-1:0]        pend_o
);

    logic            hit;
    logic            hit_ready;
    logic [XLEN-1:0] hit_data;
    logic [PW-1:0]   n_match;

    // NOTE: every signal written here gets a default first, so no path leaves a latch.
    always_comb begin
        data_o    = '0;
        pend_o    = '0;
        hit       = 1'b0;
        hit_ready = 1'b0;
        hit_data  = '0;
        n_match   = '0;
        // Walk oldest to youngest so the lowest matching index wins.
        for (int n = NFWD - 1; n >= 0; n--) begin
            if (fwd_valid_i[n] && (fwd_rd_i[n*REGW +: REGW] == idx_i)) begin
                hit       = 1'b1;
                hit_ready = fwd_ready_i[n];
                hit_data  = fwd_data_i[n*XLEN +: XLEN];
                n_match   = n_match + PW'(1);
            end
        end
        if (idx_i == '0) begin
            data_o = '0;
        end else if (hit) begin
            if (hit_ready) data_o = hit_data;
            else           pend_o = n_match;
        end else if (wb_valid_i && (wb_rd_i == idx_i)) begin
            data_o = wb_data_i;
        end else begin
            data_o = rf_rdata_i;
        end
    end

endmodule

// File: rtl/decode_stage_pipe.sv
// One-entry registered decode slot with valid/ready handshakes; operands waiting on an
// in-flight producer are resolved inside the slot by counting in-order writebacks.
module decode_stage_pipe
    import decode_stage_pipe_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int REGW = REGW_DEF,
    parameter int NFWD = NFWD_DEF,
    parameter int GHW  = GHW_DEF
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_pc,
    input  logic [31:0]          in_instr,
    input  logic                 in_prediction,
    input  logic [GHW-1:0]       in_ghist,
    input  logic [REGW-1:0]      in_rs0,
    input  logic [REGW-1:0]      in_rs1,
    input  logic [REGW-1:0]      in_rd,
    output logic [REGW-1:0]      rf_raddr0,
    output logic [REGW-1:0]      rf_raddr1,
    input  logic [XLEN-1:0]      rf_rdata0,
    input  logic [XLEN-1:0]      rf_rdata1,
    input  logic [NFWD-1:0]      fwd_valid,
    input  logic [NFWD*REGW-1:0] fwd_rd,
    input  logic [NFWD-1:0]      fwd_ready,
    input  logic [NFWD*XLEN-1:0] fwd_data,
    input  logic                 wb_valid,
    input  logic [REGW-1:0]      wb_rd,
    input  logic [XLEN-1:0]      wb_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_pc,
    output logic [31:0]          out_instr,
    output logic                 out_prediction,
    output logic [GHW-1:0]       out_ghist,
    output logic [REGW-1:0]      out_rs0,
    output logic [REGW-1:0]      out_rs1,
    output logic [REGW-1:0]      out_rd,
    output logic [XLEN-1:0]      out_rdata0,
    output logic [XLEN-1:0]      out_rdata1
);

    localparam int PW = $clog2(NFWD + 1);

    logic            occ_q, occ_d, valid_q, valid_d;
    logic [PW-1:0]   pend0_q, pend0_d, pend1_q, pend1_d;
    logic [31:0]     pc_q, pc_d, instr_q, instr_d;
    logic            pred_q, pred_d;
    logic [GHW-1:0]  ghist_q, ghist_d;
    logic [REGW-1:0] rs0_q, rs0_d, rs1_q, rs1_d, rd_q, rd_d;
    logic [XLEN-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;

    logic [XLEN-1:0] cap_data0, cap_data1;
    logic [PW-1:0]   cap_pend0, cap_pend1;
    logic            capture, dequeue;

    assign rf_raddr0 = in_rs0;
    assign rf_raddr1 = in_rs1;
    assign in_ready  = !occ_q || (valid_q && out_ready);
    assign capture   = in_valid && in_ready && !flush;
    assign dequeue   = valid_q && out_ready;

    operand_resolve #(.XLEN(XLEN), .REGW(REGW), .NFWD(NFWD), .PW(PW)) u_res0 (
        .idx_i(in_rs0), .fwd_valid_i(fwd_valid), .fwd_rd_i(fwd_rd), .fwd_ready_i(fwd_ready),
        .fwd_data_i(fwd_data), .wb_valid_i(wb_valid), .wb_rd_i(wb_rd), .wb_data_i(wb_data),
        .rf_rdata_i(rf_rdata0), .data_o(cap_data0), .pend_o(cap_pend0)
    );

    operand_resolve #(.XLEN(XLEN), .REGW(REGW), .NFWD(NFWD), .PW(PW)) u_res1 (
        .idx_i(in_rs1), .fwd_valid_i(fwd_valid), .fwd_rd_i(fwd_rd), .fwd_ready_i(fwd_ready),
        .fwd_data_i(fwd_data), .wb_valid_i(wb_valid), .wb_rd_i(wb_rd), .wb_data_i(wb_data),
        .rf_rdata_i(rf_rdata1), .data_o(cap_data1), .pend_o(cap_pend1)
    );

    always_comb begin
        occ_d    = occ_q;
        pend0_d  = pend0_q;
        pend1_d  = pend1_q;
        pc_d     = pc_q;
        instr_d  = instr_q;
        pred_d   = pred_q;
        ghist_d  = ghist_q;
        rs0_d    = rs0_q;
        rs1_d    = rs1_q;
        rd_d     = rd_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;

        if (flush) begin
            occ_d   = 1'b0;
            pend0_d = '0;
            pend1_d = '0;
        end else if (capture) begin
            occ_d    = 1'b1;
            pc_d     = in_pc;
            instr_d  = in_instr;
            pred_d   = in_prediction;
            ghist_d  = in_ghist;
            rs0_d    = in_rs0;
            rs1_d    = in_rs1;
            rd_d     = in_rd;
            rdata0_d = cap_data0;
            rdata1_d = cap_data1;
            pend0_d  = cap_pend0;
            pend1_d  = cap_pend1;
        end else if (dequeue) begin
            occ_d = 1'b0;
        end else if (occ_q) begin
            // The commit that brings a count to zero is the youngest producer's value.
            if ((pend0_q != '0) && wb_valid && (wb_rd == rs0_q)) begin
                pend0_d = pend0_q - PW'(1);
                if (pend0_q == PW'(1)) rdata0_d = wb_data;
            end
            if ((pend1_q != '0) && wb_valid && (wb_rd == rs1_q)) begin
                pend1_d = pend1_q - PW'(1);
                if (pend1_q == PW'(1)) rdata1_d = wb_data;
            end
        end

        valid_d = occ_d && (pend0_d == '0) && (pend1_d == '0);
    end

    // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            occ_q    <= 1'b0;
            valid_q  <= 1'b0;
            pend0_q  <= '0;
            pend1_q  <= '0;
            pc_q     <= '0;
            instr_q  <= '0;
            pred_q   <= 1'b0;
            ghist_q  <= '0;
            rs0_q    <= '0;
            rs1_q    <= '0;
            rd_q     <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            occ_q    <= occ_d;
            valid_q  <= valid_d;
            pend0_q  <= pend0_d;
            pend1_q  <= pend1_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            pred_q   <= pred_d;
            ghist_q  <= ghist_d;
            rs0_q    <= rs0_d;
            rs1_q    <= rs1_d;
            rd_q     <= rd_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    assign out_valid      = valid_q;
    assign out_pc         = pc_q;
    assign out_instr      = instr_q;
    assign out_prediction = pred_q;
    assign out_ghist      = ghist_q;
    assign out_rs0        = rs0_q;
    assign out_rs1        = rs1_q;
    assign out_rd         = rd_q;
    assign out_rdata0     = rdata0_q;
    assign out_rdata1     = rdata1_q;

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Directed bench for decode_stage_pipe: a slot-level reference model checked every cycle,
// plus hand-computed expectations for each scenario.
module tb_decode_stage_pipe;
    import decode_stage_pipe_pkg::*;

    localparam int XLEN = 32;
    localparam int REGW = 6;
    localparam int NFWD = 2;
    localparam int GHW  = 9;

    logic                 clk = 1'b0;
    logic                 rstn, flush, in_valid, in_ready, in_prediction;
    logic [31:0]          in_pc, in_instr;
    logic [GHW-1:0]       in_ghist;
    logic [REGW-1:0]      in_rs0, in_rs1, in_rd, rf_raddr0, rf_raddr1, wb_rd;
    logic [XLEN-1:0]      rf_rdata0, rf_rdata1, wb_data;
    logic [NFWD-1:0]      fwd_valid, fwd_ready;
    logic [NFWD*REGW-1:0] fwd_rd;
    logic [NFWD*XLEN-1:0] fwd_data;
    logic                 wb_valid, out_valid, out_ready, out_prediction;
    logic [31:0]          out_pc, out_instr;
    logic [GHW-1:0]       out_ghist;
    logic [REGW-1:0]      out_rs0, out_rs1, out_rd;
    logic [XLEN-1:0]      out_rdata0, out_rdata1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    decode_stage_pipe #(.XLEN(XLEN), .REGW(REGW), .NFWD(NFWD), .GHW(GHW)) dut (
        .clk(clk), .rstn(rstn), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_instr(in_instr), .in_prediction(in_prediction), .in_ghist(in_ghist),
        .in_rs0(in_rs0), .in_rs1(in_rs1), .in_rd(in_rd),
        .rf_raddr0(rf_raddr0), .rf_raddr1(rf_raddr1), .rf_rdata0(rf_rdata0), .rf_rdata1(rf_rdata1),
        .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_ready(fwd_ready), .fwd_data(fwd_data),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
        .out_prediction(out_prediction), .out_ghist(out_ghist), .out_rs0(out_rs0),
        .out_rs1(out_rs1), .out_rd(out_rd), .out_rdata0(out_rdata0), .out_rdata1(out_rdata1)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [XLEN-1:0] data;
        int unsigned     pend;
    } res_t;

    decode_slot_t m_slot;
    logic         m_occ;
    int unsigned  m_wait0, m_wait1;

    function automatic res_t resolve(input logic [REGW-1:0] idx, input logic [XLEN-1:0] rf);
        res_t r;
        int   first;
        int   cnt;
        r.data = '0;
        r.pend = 0;
        first  = -1;
        cnt    = 0;
        if (idx == '0) return r;
        for (int n = 0; n < NFWD; n++) begin
            if (fwd_valid[n] && fwd_rd[n*REGW +: REGW] == idx) begin
                cnt++;
                if (first < 0) first = n;
            end
        end
        if (first >= 0) begin
            if (fwd_ready[first]) r.data = fwd_data[first*XLEN +: XLEN];
            else                  r.pend = cnt;
        end else if (wb_valid && wb_rd == idx) begin
            r.data = wb_data;
        end else begin
            r.data = rf;
        end
        return r;
    endfunction

    function automatic logic exp_valid();
        return m_occ && m_wait0 == 0 && m_wait1 == 0;
    endfunction

    always @(posedge clk or negedge rstn) begin : model
        decode_slot_t s;
        logic         occ;
        int unsigned  w0, w1;
        res_t         r0, r1;
        if (!rstn) begin
            m_occ   <= 1'b0;
            m_slot  <= '0;
            m_wait0 <= 0;
            m_wait1 <= 0;
        end else begin
            s   = m_slot;
            occ = m_occ;
            w0  = m_wait0;
            w1  = m_wait1;
            if (flush) begin
                occ = 1'b0;
                w0  = 0;
                w1  = 0;
            end else if (in_valid && (!m_occ || (exp_valid() && out_ready))) begin
                r0 = resolve(in_rs0, rf_rdata0);
                r1 = resolve(in_rs1, rf_rdata1);
                s  = '{pc: in_pc, instr: in_instr, prediction: in_prediction, ghist: in_ghist,
                       rs0: in_rs0, rs1: in_rs1, rd: in_rd, rdata0: r0.data, rdata1: r1.data};
                occ = 1'b1;
                w0  = r0.pend;
                w1  = r1.pend;
            end else if (exp_valid() && out_ready) begin
                occ = 1'b0;
            end else if (m_occ && wb_valid) begin
                if (w0 > 0 && wb_rd == s.rs0) begin
                    w0--;
                    if (w0 == 0) s.rdata0 = wb_data;
                end
                if (w1 > 0 && wb_rd == s.rs1) begin
                    w1--;
                    if (w1 == 0) s.rdata1 = wb_data;
                end
            end
            m_slot  <= s;
            m_occ   <= occ;
            m_wait0 <= w0;
            m_wait1 <= w1;
        end
    end

    always @(negedge clk) begin
        if (rstn) begin
            check("in_ready", in_ready, !m_occ || (exp_valid() && out_ready));
            check("out_valid", out_valid, exp_valid());
            check("rf_raddr0", rf_raddr0, in_rs0);
            check("rf_raddr1", rf_raddr1, in_rs1);
            if (exp_valid()) begin
                check("out_pc", out_pc, m_slot.pc);
                check("out_instr", out_instr, m_slot.instr);
                check("out_prediction", out_prediction, m_slot.prediction);
                check("out_ghist", out_ghist, m_slot.ghist);
                check("out_rs0", out_rs0, m_slot.rs0);
                check("out_rs1", out_rs1, m_slot.rs1);
                check("out_rd", out_rd, m_slot.rd);
                check("out_rdata0", out_rdata0, m_slot.rdata0);
                check("out_rdata1", out_rdata1, m_slot.rdata1);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic set_fwd(input int n, input logic v, input logic [REGW-1:0] rd,
                           input logic rdy, input logic [XLEN-1:0] d);
        fwd_valid[n]             = v;
        fwd_rd[n*REGW +: REGW]   = rd;
        fwd_ready[n]             = rdy;
        fwd_data[n*XLEN +: XLEN] = d;
    endtask

    task automatic clear_fwd();
        fwd_valid = '0;
        fwd_rd    = '0;
        fwd_ready = '0;
        fwd_data  = '0;
    endtask

    task automatic send(input logic [31:0] pc, input logic [REGW-1:0] rs0,
                        input logic [REGW-1:0] rs1, input logic [REGW-1:0] rd);
        in_valid      = 1'b1;
        in_pc         = pc;
        in_instr      = pc ^ 32'h0013_0000;
        in_prediction = pc[2];
        in_ghist      = pc[8:0] ^ 9'h1A5;
        in_rs0        = rs0;
        in_rs1        = rs1;
        in_rd         = rd;
    endtask

    initial begin
        rstn = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_pc = '0; in_instr = '0; in_prediction = 1'b0; in_ghist = '0;
        in_rs0 = '0; in_rs1 = '0; in_rd = '0; rf_rdata0 = '0; rf_rdata1 = '0;
        wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
        clear_fwd();

        #2;
        check("reset out_valid", out_valid, 1'b0);
        check("reset in_ready", in_ready, 1'b1);
        check("reset out_pc", out_pc, 32'h0);
        check("reset out_rdata0", out_rdata0, 32'h0);
        #10 rstn = 1'b1;

        // No hazard: register file operand, x0 on the other port.
        send(32'h100, 6'd5, 6'd0, 6'd3);
        rf_rdata0 = 32'h11; rf_rdata1 = 32'h99;
        cycle();
        in_valid = 1'b0;
        @(negedge clk);
        check("nohaz out_valid", out_valid, 1'b1);
        check("nohaz rdata0", out_rdata0, 32'h11);
        check("nohaz rdata1 x0", out_rdata1, 32'h0);

        // Youngest forward wins.
        send(32'h104, 6'd5, 6'd6, 6'd4);
        rf_rdata1 = 32'h66;
        set_fwd(0, 1'b1, 6'd5, 1'b1, 32'hA);
        set_fwd(1, 1'b1, 6'd5, 1'b1, 32'hB);
        cycle();
        in_valid = 1'b0; clear_fwd();
        @(negedge clk);
        check("prio rdata0", out_rdata0, 32'hA);
        check("prio rdata1", out_rdata1, 32'h66);

        // Load pending on two sources, resolved by two commits.
        send(32'h108, 6'd0, 6'd7, 6'd8);
        set_fwd(0, 1'b1, 6'd7, 1'b0, 32'hDEAD);
        set_fwd(1, 1'b1, 6'd7, 1'b0, 32'hBEEF);
        cycle();
        in_valid = 1'b0; clear_fwd();
        @(negedge clk);
        check("pend out_valid", out_valid, 1'b0);
        check("pend in_ready", in_ready, 1'b0);
        wb_valid = 1'b1; wb_rd = 6'd7; wb_data = 32'h1;
        cycle();
        wb_rd = 6'd8; wb_data = 32'h3;
        cycle();
        wb_rd = 6'd7; wb_data = 32'h2;
        cycle();
        wb_valid = 1'b0;
        @(negedge clk);
        check("pend resolved valid", out_valid, 1'b1);
        check("pend resolved rdata1", out_rdata1, 32'h2);

        // Backpressure holds the slot, then back-to-back replacement.
        out_ready = 1'b0;
        send(32'h10C, 6'd5, 6'd0, 6'd1);
        rf_rdata0 = 32'h22;
        for (int i = 0; i < 3; i++) begin
            cycle();
            @(negedge clk);
            check("bp in_ready", in_ready, 1'b0);
            check("bp out_pc", out_pc, 32'h108);
            check("bp out_valid", out_valid, 1'b1);
        end
        out_ready = 1'b1;
        cycle();
        in_valid = 1'b0;
        @(negedge clk);
        check("b2b out_valid", out_valid, 1'b1);
        check("b2b out_pc", out_pc, 32'h10C);
        check("b2b rdata0", out_rdata0, 32'h22);

        // Flush while an operand is pending; a later commit must not revive it.
        send(32'h110, 6'd9, 6'd0, 6'd2);
        set_fwd(0, 1'b1, 6'd9, 1'b0, 32'h0);
        cycle();
        clear_fwd();
        send(32'h114, 6'd1, 6'd0, 6'd2);
        flush = 1'b1;
        cycle();
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("flush out_valid", out_valid, 1'b0);
        check("flush in_ready", in_ready, 1'b1);
        wb_valid = 1'b1; wb_rd = 6'd9; wb_data = 32'h77;
        cycle();
        wb_valid = 1'b0;
        @(negedge clk);
        check("post-flush wb", out_valid, 1'b0);

        // x0 ignores forwarding; same-cycle writeback bypass.
        send(32'h118, 6'd0, 6'd12, 6'd5);
        set_fwd(0, 1'b1, 6'd0, 1'b1, 32'hFFFF);
        wb_valid = 1'b1; wb_rd = 6'd12; wb_data = 32'h55;
        rf_rdata1 = 32'h66;
        cycle();
        in_valid = 1'b0; wb_valid = 1'b0; clear_fwd();
        @(negedge clk);
        check("x0 rdata0", out_rdata0, 32'h0);
        check("wb bypass rdata1", out_rdata1, 32'h55);

        // Float f0 is not x0; f5 must not match an integer x5 forward.
        send(32'h11C, 6'h20, 6'h25, 6'h21);
        rf_rdata0 = 32'h44; rf_rdata1 = 32'h88;
        set_fwd(1, 1'b1, 6'h05, 1'b1, 32'hBB);
        cycle();
        in_valid = 1'b0; clear_fwd();
        @(negedge clk);
        check("f0 rdata0", out_rdata0, 32'h44);
        check("f5 rdata1", out_rdata1, 32'h88);

        // Reset while pending returns to the reset state immediately.
        send(32'h120, 6'd0, 6'd7, 6'd3);
        set_fwd(0, 1'b1, 6'd7, 1'b0, 32'h0);
        cycle();
        in_valid = 1'b0; clear_fwd();
        @(negedge clk);
        check("rst-pend out_valid", out_valid, 1'b0);
        #1 rstn = 1'b0;
        #1;
        check("midrst out_valid", out_valid, 1'b0);
        check("midrst in_ready", in_ready, 1'b1);
        check("midrst out_pc", out_pc, 32'h0);
        check("midrst out_rs1", out_rs1, 6'd0);
        check("midrst out_rdata1", out_rdata1, 32'h0);
        #1 rstn = 1'b1;
        wb_valid = 1'b1; wb_rd = 6'd7; wb_data = 32'h9;
        cycle();
        wb_valid = 1'b0;
        @(negedge clk);
        check("post-rst wb", out_valid, 1'b0);
        repeat (2) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
